// File: rtl/capture_sequencer.sv
// capture_sequencer: runs one capture of the ramp source into the transfer FIFO (flush, capture, drain, done).
// Latency: fifo_reset high t+1..t+FLUSH_CYCLES after a start edge at t, first src_enable at t+FLUSH_CYCLES+1; outputs registered.
// Backpressure: with CAPSEQ_STALL_EN defined, fifo_full pauses src_enable; otherwise capture runs on and sets sticky overflow.
module capture_sequencer #(
   parameter int CNT_W        = 16,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] length,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   output logic             src_enable,
   output logic             fifo_reset,
   output logic [CNT_W-1:0] sample_count,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_CAPTURE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

   state_t             state_q, state_d;
   logic               start_q;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_inc;
   logic [7:0]         flush_q, flush_d;
   logic               src_en_q, src_en_d;
   logic               frst_q, frst_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               start_edge;
   logic               src_ok;

   assign start_edge = start & ~start_q;
   assign cnt_inc    = cnt_q + CNT_W'(1);

   // Next state and next registered outputs; abort outranks every other input outside IDLE
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      flush_d  = flush_q;
      src_en_d = 1'b0;
      frst_d   = 1'b0;
      ovf_d    = ovf_q;
      src_ok   = 1'b1;

      // A sample issued this cycle is counted even if the run is aborted in the same cycle
      if (src_en_q) begin
         cnt_d = cnt_inc;
      end

`ifdef CAPSEQ_STALL_EN
      src_ok = ~fifo_full;
`else
      src_ok = 1'b1;
      if (src_en_q && fifo_full) begin
         ovf_d = 1'b1;
      end
`endif

      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         frst_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_edge) begin
                  state_d = ST_FLUSH;
                  len_d   = length;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  flush_d = '0;
                  frst_d  = 1'b1;
               end else if ((state_q == ST_DONE) && !start) begin
                  state_d = ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (flush_q == FLUSH_LAST) begin
                  if (len_q == '0) begin
                     state_d = ST_DRAIN;
                  end else begin
                     state_d  = ST_CAPTURE;
                     src_en_d = src_ok;
                  end
               end else begin
                  flush_d = flush_q + 8'd1;
                  frst_d  = 1'b1;
               end
            end
            ST_CAPTURE: begin
               // The sample that brings the count to length is the last one of the run
               if (src_en_q && (cnt_inc == len_q)) begin
                  state_d = ST_DRAIN;
               end else begin
                  src_en_d = src_ok;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d == ST_FLUSH) || (state_d == ST_CAPTURE) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   // State register, start-edge history and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         flush_q  <= '0;
         src_en_q <= 1'b0;
         frst_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         src_en_q <= src_en_d;
         frst_q   <= frst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign src_enable   = src_en_q;
   assign fifo_reset   = frst_q;
   assign sample_count = cnt_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: drives capture runs and compares each cycle against an interval-based run model.
// Latency: model places flush, capture window, drain and done as arithmetic offsets from the start edge.
// Backpressure: fifo_full patterns are bench-chosen; overflow expectation derives from the capture window.
module tb_capture_sequencer;

   localparam int CNT_W = 16;
   localparam int F     = 4;

   logic             clock;
   logic             reset;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] length;
   logic             fifo_full;
   logic             fifo_empty;
   logic             src_enable;
   logic             fifo_reset;
   logic [CNT_W-1:0] sample_count;
   logic             busy;
   logic             done;
   logic             overflow;

   int checks = 0;
   int errors = 0;
   int prev_count = 0;
   bit prev_ovf = 1'b0;

   capture_sequencer #(.CNT_W(CNT_W), .FLUSH_CYCLES(F)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .length       (length),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .src_enable   (src_enable),
      .fifo_reset   (fifo_reset),
      .sample_count (sample_count),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

`ifdef CAPSEQ_STALL_EN
   localparam bit STALL = 1'b1;
`else
   localparam bit STALL = 1'b0;
`endif

   // One full run: start edge at offset 0, outputs checked at every offset against the interval model.
   // fmode: 0 never full, 1 full for capture cycles 4..6, 2 random full.
   task automatic run_capture(input string nm, input int L, input int E, input int H,
                              input bit glitch, input int fmode);
      bit full_arr[0:255];
      int extra, win_lo, win_hi, d0, dn, s, last;
      int bad_frst, bad_src, bad_busy, bad_done, bad_cnt, bad_ovf;
      int frst_total, src_total, src_first, src_last, exp_cnt;
      bit inwin, ovf_acc;
      extra   = (STALL && fmode == 1) ? 3 : 0;
      win_lo  = F + 1;
      win_hi  = F + L + extra;
      d0      = F + 1 + L + extra;
      dn      = d0 + E;
      s       = dn + 1 + H;
      last    = s + 2;
      for (int o = 0; o < 256; o++) begin
         case (fmode)
            1:       full_arr[o] = (o >= F + 4) && (o <= F + 6);
            2:       full_arr[o] = ($urandom_range(0, 5) == 0);
            default: full_arr[o] = 1'b0;
         endcase
      end
      bad_frst = 0; bad_src = 0; bad_busy = 0; bad_done = 0; bad_cnt = 0; bad_ovf = 0;
      frst_total = 0; src_total = 0; src_first = -1; src_last = -1;
      ovf_acc = 1'b0;
      tick();
      start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
      for (int o = 0; o <= last; o++) begin
         tick();
         inwin = (o >= win_lo) && (o <= win_hi);
         if (fifo_reset) frst_total++;
         if (src_enable) begin
            src_total++;
            if (src_first < 0) src_first = o;
            src_last = o;
         end
         if (fifo_reset !== ((o >= 1) && (o <= F))) bad_frst++;
         if (STALL && fmode != 0) begin
            if (src_enable && !inwin) bad_src++;
         end else begin
            if (src_enable !== inwin) bad_src++;
            exp_cnt = (o <= 0) ? prev_count : (o - win_lo < 0) ? 0 : (o - win_lo > L) ? L : o - win_lo;
            if (sample_count !== CNT_W'(exp_cnt)) bad_cnt++;
         end
         if (busy !== ((o >= 1) && (o <= dn))) bad_busy++;
         if (done !== ((o >= dn + 1) && (o <= s))) bad_done++;
         if (overflow !== ((o <= 0) ? prev_ovf : ovf_acc)) bad_ovf++;
         if (!STALL && inwin && full_arr[o]) ovf_acc = 1'b1;
         // Inputs for cycle o
         if (o == 0)                          start = 1'b1;
         else if (o >= s)                     start = 1'b0;
         else if (glitch && o == F + 2)       start = 1'b0;
         else                                 start = 1'b1;
         length     = (o == 0) ? CNT_W'(L) : CNT_W'($urandom);
         fifo_full  = full_arr[o];
         fifo_empty = (o >= dn) ? 1'b1 : (o >= d0) ? 1'b0 : 1'($urandom);
      end
      checks++; if (bad_frst !== 0) begin errors++; $display("FAIL %s fifo_reset_trace: %0d cycles differ, expected 0", nm, bad_frst); end
      checks++; if (frst_total !== F) begin errors++; $display("FAIL %s fifo_reset_len: got %0d cycles, expected %0d", nm, frst_total, F); end
      checks++; if (bad_src !== 0) begin errors++; $display("FAIL %s src_enable_trace: %0d cycles differ, expected 0", nm, bad_src); end
      checks++; if (src_total !== L) begin errors++; $display("FAIL %s src_enable_count: got %0d, expected %0d", nm, src_total, L); end
      if (L > 0) begin
         checks++; if (src_last - src_first + 1 !== L + extra) begin errors++; $display("FAIL %s src_enable_span: got %0d, expected %0d", nm, src_last - src_first + 1, L + extra); end
      end
      checks++; if (bad_busy !== 0) begin errors++; $display("FAIL %s busy_trace: %0d cycles differ, expected 0", nm, bad_busy); end
      checks++; if (bad_done !== 0) begin errors++; $display("FAIL %s done_trace: %0d cycles differ, expected 0", nm, bad_done); end
      checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL %s count_trace: %0d cycles differ, expected 0", nm, bad_cnt); end
      checks++; if (sample_count !== CNT_W'(L)) begin errors++; $display("FAIL %s final_count: got %0d, expected %0d", nm, sample_count, L); end
      checks++; if (bad_ovf !== 0) begin errors++; $display("FAIL %s overflow_trace: %0d cycles differ, expected 0", nm, bad_ovf); end
      prev_count = L;
      prev_ovf   = ovf_acc;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; length = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({src_enable, fifo_reset, busy, done, overflow} !== 5'b0 || sample_count !== '0) begin
         errors++;
         $display("FAIL reset_outputs: src=%b frst=%b busy=%b done=%b ovf=%b cnt=%0d, expected all 0",
                  src_enable, fifo_reset, busy, done, overflow, sample_count);
      end
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({src_enable, fifo_reset, busy, done} !== 4'b0) begin
         errors++;
         $display("FAIL reset_idle: src=%b frst=%b busy=%b done=%b, expected 0", src_enable, fifo_reset, busy, done);
      end
      prev_count = 0;
      prev_ovf   = 1'b0;
   endtask

   task automatic test_basic();
      run_capture("basic", 10, 2, 1, 1'b0, 0);
   endtask

   task automatic test_zero_length();
      run_capture("zero_len", 0, 3, 1, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      run_capture("full3", 8, 1, 0, 1'b0, 1);
      checks++;
      if (overflow !== !STALL) begin
         errors++;
         $display("FAIL full3_overflow: got %b, expected %b", overflow, !STALL);
      end
   endtask

   task automatic test_extra_start();
      run_capture("extra_start", 12, 1, 2, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      run_capture("hold_done", 5, 0, 6, 1'b0, 0);
      run_capture("rerun", 6, 1, 0, 1'b0, 0);
   endtask

   task automatic test_abort();
      int bad;
      tick(); start = 1'b0; length = CNT_W'(20);
      tick(); start = 1'b1;
      for (int o = 1; o <= F + 5; o++) begin
         tick();
         length = CNT_W'($urandom);
      end
      checks++;
      if (src_enable !== 1'b1 || sample_count !== CNT_W'(4)) begin
         errors++;
         $display("FAIL abort_pre: src=%b cnt=%0d, expected src=1 cnt=4", src_enable, sample_count);
      end
      abort = 1'b1;
      tick(); abort = 1'b0;
      checks++;
      if (src_enable !== 1'b0 || fifo_reset !== 1'b1 || busy !== 1'b0 || sample_count !== CNT_W'(5)) begin
         errors++;
         $display("FAIL abort_next: src=%b frst=%b busy=%b cnt=%0d, expected 0 1 0 5", src_enable, fifo_reset, busy, sample_count);
      end
      tick();
      checks++;
      if (fifo_reset !== 1'b0 || done !== 1'b0 || sample_count !== CNT_W'(5)) begin
         errors++;
         $display("FAIL abort_after: frst=%b done=%b cnt=%0d, expected 0 0 5", fifo_reset, done, sample_count);
      end
      bad = 0;
      repeat (3) begin
         tick();
         if (busy !== 1'b0 || src_enable !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL abort_idle: %0d active cycles, expected 0", bad); end
      // Abort together with a start edge in IDLE is ignored, abort in FLUSH is not
      tick(); start = 1'b0;
      tick(); start = 1'b1; abort = 1'b1; length = CNT_W'(9);
      tick();
      checks++;
      if (busy !== 1'b1 || fifo_reset !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_idle: busy=%b frst=%b, expected 1 1", busy, fifo_reset);
      end
      tick(); abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || fifo_reset !== 1'b1 || sample_count !== '0) begin
         errors++;
         $display("FAIL abort_flush: busy=%b frst=%b cnt=%0d, expected 0 1 0", busy, fifo_reset, sample_count);
      end
      tick(); start = 1'b0;
      checks++;
      if (fifo_reset !== 1'b0) begin errors++; $display("FAIL abort_flush_end: frst=%b, expected 0", fifo_reset); end
      prev_count = 0;
      prev_ovf   = 1'b0;
   endtask

   task automatic test_async_reset();
      int bad;
      tick(); start = 1'b0; length = CNT_W'(30);
      tick(); start = 1'b1;
      for (int o = 1; o <= F + 6; o++) begin
         tick();
         start = 1'b0;
      end
      checks++;
      if (src_enable !== 1'b1) begin errors++; $display("FAIL areset_pre: src=%b, expected 1", src_enable); end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({src_enable, fifo_reset, busy, done, overflow} !== 5'b0 || sample_count !== '0) begin
         errors++;
         $display("FAIL areset_now: src=%b frst=%b busy=%b done=%b ovf=%b cnt=%0d, expected all 0",
                  src_enable, fifo_reset, busy, done, overflow, sample_count);
      end
      repeat (2) tick();
      reset = 1'b1;
      bad = 0;
      repeat (6) begin
         tick();
         if ({src_enable, fifo_reset, busy, done} !== 4'b0 || sample_count !== '0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL areset_idle: %0d active cycles, expected 0", bad); end
      prev_count = 0;
      prev_ovf   = 1'b0;
   endtask

   task automatic test_random();
      int L;
      for (int r = 0; r < 12; r++) begin
         L = $urandom_range(0, 40);
         run_capture($sformatf("rand%0d", r), L, $urandom_range(0, 5), $urandom_range(0, 3),
                     (L >= 3) && ($urandom_range(0, 1) == 1), STALL ? 0 : 2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_length();
      test_backpressure();
      test_extra_start();
      test_back_to_back();
      test_abort();
      test_async_reset();
      test_basic();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Single-clock controller that sequences one capture run of the ramp source into the transfer FIFO feeding the block-throttled pipe-out. It detects a host start request from a wire-in bit and flushes the FIFO. It then gates the source enable for exactly `length` accepted samples, waits for the host to drain the FIFO, and reports completion. It sits between the wire-in endpoints and the ramp/FIFO pair, replacing direct host control of `enable` and `reset_transfer`.

## Interface
- `CNT_W`, 16, width of the sample counter and of `length`.
- `FLUSH_CYCLES`, 4, number of cycles `fifo_reset` is held high at run start; legal range 1..255.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, level from wire-in; only its rising edge is acted on.
- `abort`  in  1  synchronous abort, level; priority over all other inputs.
- `length`  in  CNT_W  samples per run; sampled on the start edge.
- `fifo_full`  in  1  transfer FIFO write-side full.
- `fifo_empty`  in  1  transfer FIFO read-side empty.
- `src_enable`  out  1  enable to the ramp source; one sample written per high cycle.
- `fifo_reset`  out  1  active-high FIFO reset.
- `sample_count`  out  CNT_W  samples accepted in the current/last run.
- `busy`  out  1  high in any state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `overflow`  out  1  sticky: a sample was produced while `fifo_full` was high. Cleared on the next start edge.

## Operation
- All outputs are registered. Under reset, every output is 0, the state is IDLE, and the start-edge register is 0.
- Start edge = `start` high now and low in the previous cycle.
- States and transitions:
  - IDLE: on a start edge, latch `length`, clear `sample_count` and `overflow`, and go to FLUSH.
  - FLUSH: `fifo_reset`=1 for exactly FLUSH_CYCLES cycles, then go to CAPTURE. If `length`==0, go directly to DRAIN instead.
  - CAPTURE: `src_enable` is driven per Configuration. Each cycle `src_enable` is high, `sample_count` increments by 1. In the cycle the count reaches `length`, deassert `src_enable` and go to DRAIN.
  - DRAIN: wait for `fifo_empty`=1, then go to DONE.
  - DONE: `done`=1. When `start` is low, go to IDLE. A new start edge while in DONE behaves exactly as in IDLE.
- Abort: in any state other than IDLE, `abort`=1 forces, in the next cycle, `src_enable`=0, one cycle of `fifo_reset`=1, and state IDLE. `sample_count` is held. `abort` in IDLE has no effect.
- Start edges in FLUSH, CAPTURE or DRAIN are ignored; runs never re-arm mid-flight.
- `length` changes after the start edge have no effect on the current run.
- `sample_count` never exceeds the latched length and never wraps. The counter compare is full-width unsigned equality.

## Timing
- Start edge in cycle t produces:
  - `fifo_reset` high for cycles t+1 .. t+FLUSH_CYCLES;
  - first `src_enable` high at t+FLUSH_CYCLES+1.
- With no backpressure, `src_enable` stays high for exactly `length` consecutive cycles.
- `busy` rises at t+1. It falls in the same cycle `done` rises, which is one cycle after `fifo_empty` is seen in DRAIN.
- `overflow` sets one cycle after the offending cycle.

## Configuration
- `CAPSEQ_STALL_EN` defined:
  - `src_enable` is forced low in any CAPTURE cycle where `fifo_full`=1; no sample is lost and the count pauses.
  - `overflow` is never set.
- Not defined:
  - `src_enable` stays high regardless of `fifo_full`, and the count continues.
  - Each such cycle sets `overflow`.

## Test plan
- FLUSH_CYCLES=4, `length`=10, `start` pulses 0→1, FIFO never full:
  - `fifo_reset` high for 4 cycles;
  - `src_enable` high for exactly 10 cycles;
  - `sample_count`=10;
  - `done`=1 after `fifo_empty`.
- `length`=0:
  - no `src_enable` pulse;
  - FLUSH → DRAIN → DONE;
  - `sample_count`=0.
- `length`=8, `fifo_full` high for 3 cycles mid-capture:
  - with `CAPSEQ_STALL_EN`, `src_enable` is high for 8 cycles over 11, and `overflow`=0;
  - without it, `src_enable` is high for 8 cycles, and `overflow`=1.
- `abort` at the 5th CAPTURE cycle with `length`=20:
  - next cycle `src_enable`=0 and one cycle of `fifo_reset`=1;
  - state IDLE with `sample_count`=5.
- Extra start edges during CAPTURE are ignored.
- Holding `start` high through DONE keeps `done`=1. Dropping `start` returns to IDLE, and a new edge re-runs with the count cleared.
- `reset` asserted low mid-CAPTURE:
  - all outputs are 0 immediately (asynchronous);
  - after release, the block stays idle until a fresh start edge.
